// File: rtl/ct_l2c_spsram_acc_ctrl.sv
// Write/read arbiter and read-return FIFO in front of one 512x96 single-port L2C SRAM.
// Optional performance counters are enabled by defining CT_L2C_SRAM_ACC_PERF_EN.
module ct_l2c_spsram_acc_ctrl #(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 96,
    parameter int RD_FIFO_DEPTH = 2,
    parameter int WR_STARVE_MAX = 4
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  wr_req_vld,
    output logic                  wr_req_rdy,
    input  logic [ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [DATA_WIDTH-1:0] wr_req_data,
    input  logic [DATA_WIDTH-1:0] wr_req_bmask,
    input  logic                  rd_req_vld,
    output logic                  rd_req_rdy,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    output logic                  rd_data_vld,
    input  logic                  rd_data_rdy,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
`ifdef CT_L2C_SRAM_ACC_PERF_EN
    ,
    output logic [31:0]           perf_rd_stall_cnt,
    output logic [31:0]           perf_wr_cnt
`endif
);

    localparam int PTR_W = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(RD_FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(WR_STARVE_MAX + 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RD_FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(RD_FIFO_DEPTH);
    localparam logic [STV_W-1:0] STV_MAX_C = STV_W'(WR_STARVE_MAX);

    logic [DATA_WIDTH-1:0] r_fifo [RD_FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_inflight;
    logic [STV_W-1:0]      r_starve;

    logic                  w_pop;
    logic                  w_push;
    logic [CNT_W-1:0]      w_cnt_after_pop;
    logic [CNT_W:0]        w_credit;
    logic                  w_rd_ok;
    logic                  w_starved;
    logic                  w_rd_gnt;
    logic                  w_wr_gnt;

    assign rd_data_vld = (r_cnt != '0);
    assign rd_data     = rd_data_vld ? r_fifo[r_rptr] : '0;

    // Credit counts a read still in the SRAM pipe as already occupying a FIFO slot,
    // so the push one cycle later can never find the FIFO full.
    assign w_pop           = rd_data_vld & rd_data_rdy;
    assign w_push          = r_inflight;
    assign w_cnt_after_pop = r_cnt - CNT_W'(w_pop);
    assign w_credit        = {1'b0, w_cnt_after_pop} + {{CNT_W{1'b0}}, r_inflight};
    assign w_rd_ok         = (w_credit < DEPTH_C);

    assign w_starved  = (r_starve == STV_MAX_C);
    assign w_rd_gnt   = rd_req_vld & w_rd_ok & (~wr_req_vld | w_starved);
    assign w_wr_gnt   = wr_req_vld & ~w_rd_gnt;
    assign rd_req_rdy = w_rd_gnt;
    assign wr_req_rdy = w_wr_gnt;

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (w_wr_gnt) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~wr_req_bmask;
            sram_a    = wr_req_addr;
            sram_d    = wr_req_data;
        end else if (w_rd_gnt) begin
            sram_cen  = 1'b0;
            sram_a    = rd_req_addr;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_starve <= '0;
        end else if (w_rd_gnt || !(rd_req_vld && w_rd_ok)) begin
            r_starve <= '0;
        end else if (w_wr_gnt && !w_starved) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
        end else begin
            r_inflight <= w_rd_gnt;
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Storage is not reset: entries are only visible through rd_data_vld.
    always_ff @(posedge forever_cpuclk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= sram_q;
        end
    end

    a_no_overflow: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
        w_push |-> ({1'b0, w_cnt_after_pop} < DEPTH_C));

`ifdef CT_L2C_SRAM_ACC_PERF_EN
    logic [31:0] r_perf_rd_stall_cnt;
    logic [31:0] r_perf_wr_cnt;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_perf_rd_stall_cnt <= '0;
            r_perf_wr_cnt       <= '0;
        end else begin
            if (rd_req_vld && !w_rd_gnt && (r_perf_rd_stall_cnt != '1)) begin
                r_perf_rd_stall_cnt <= r_perf_rd_stall_cnt + 32'd1;
            end
            if (w_wr_gnt && (r_perf_wr_cnt != '1)) begin
                r_perf_wr_cnt <= r_perf_wr_cnt + 32'd1;
            end
        end
    end

    assign perf_rd_stall_cnt = r_perf_rd_stall_cnt;
    assign perf_wr_cnt       = r_perf_wr_cnt;
`endif

endmodule

// File: tb/tb_ct_l2c_spsram_acc_ctrl.sv
// Bench for ct_l2c_spsram_acc_ctrl: directed scenarios plus random traffic against a
// transaction-level model (reference memory and a queue of outstanding reads).
module tb_ct_l2c_spsram_acc_ctrl;

    localparam int DEPTH  = 2;
    localparam int STARVE = 4;

    logic        clk;
    logic        cpurst_b;
    logic        wr_req_vld;
    logic        wr_req_rdy;
    logic [8:0]  wr_req_addr;
    logic [95:0] wr_req_data;
    logic [95:0] wr_req_bmask;
    logic        rd_req_vld;
    logic        rd_req_rdy;
    logic [8:0]  rd_req_addr;
    logic        rd_data_vld;
    logic        rd_data_rdy;
    logic [95:0] rd_data;
    logic [8:0]  sram_a;
    logic        sram_cen;
    logic        sram_gwen;
    logic [95:0] sram_wen;
    logic [95:0] sram_d;
    logic [95:0] sram_q;
`ifdef CT_L2C_SRAM_ACC_PERF_EN
    logic [31:0] perf_rd_stall_cnt;
    logic [31:0] perf_wr_cnt;
`endif

    ct_l2c_spsram_acc_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst_b       (cpurst_b),
        .wr_req_vld     (wr_req_vld),
        .wr_req_rdy     (wr_req_rdy),
        .wr_req_addr    (wr_req_addr),
        .wr_req_data    (wr_req_data),
        .wr_req_bmask   (wr_req_bmask),
        .rd_req_vld     (rd_req_vld),
        .rd_req_rdy     (rd_req_rdy),
        .rd_req_addr    (rd_req_addr),
        .rd_data_vld    (rd_data_vld),
        .rd_data_rdy    (rd_data_rdy),
        .rd_data        (rd_data),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
`ifdef CT_L2C_SRAM_ACC_PERF_EN
        ,
        .perf_rd_stall_cnt (perf_rd_stall_cnt),
        .perf_wr_cnt       (perf_wr_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port SRAM: one-cycle read latency, bit-masked writes.
    logic [95:0] sram_mem [0:511];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= sram_mem[sram_a];
        end
    end

    typedef struct {
        logic [95:0] d;
        int          avail;
    } rd_t;

    rd_t         rq[$];
    logic [95:0] ref_mem [0:511];
    int          cyc_n;
    int          streak;
    int          n_chk;
    int          n_fail;
    bit          last_rd;
    bit          last_wr;
    bit          last_vld;
    logic [95:0] last_data;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        streak = 0;
    endtask

    // One clock cycle: check the DUT against the model at the falling edge, then advance.
    task automatic step();
        bit          exp_vld, pop, rd_ok, rg, wg;
        logic [95:0] e_wen, e_d;
        logic [8:0]  e_a;
        logic        e_cen, e_gwen;
        rd_t         e;
        @(negedge clk);
        exp_vld = (rq.size() > 0) && (rq[0].avail <= cyc_n);
        pop     = exp_vld && rd_data_rdy;
        rd_ok   = (rq.size() - int'(pop)) < DEPTH;
        rg      = rd_req_vld && rd_ok && (!wr_req_vld || streak == STARVE);
        wg      = wr_req_vld && !rg;
        e_cen = 1'b1; e_gwen = 1'b1; e_wen = '1; e_a = '0; e_d = '0;
        if (wg) begin
            e_cen = 1'b0; e_gwen = 1'b0; e_wen = ~wr_req_bmask; e_a = wr_req_addr; e_d = wr_req_data;
        end else if (rg) begin
            e_cen = 1'b0; e_a = rd_req_addr;
        end
        chk("rd_data_vld", rd_data_vld, exp_vld);
        if (exp_vld) chk("rd_data", rd_data, rq[0].d);
        chk("rd_req_rdy", rd_req_rdy, rg);
        chk("wr_req_rdy", wr_req_rdy, wg);
        chk("sram_cen", sram_cen, e_cen);
        chk("sram_gwen", sram_gwen, e_gwen);
        chk("sram_wen", sram_wen, e_wen);
        chk("sram_a", sram_a, e_a);
        chk("sram_d", sram_d, e_d);
        last_vld  = rd_data_vld;
        last_data = rd_data;
        if (pop) void'(rq.pop_front());
        if (wg) ref_mem[wr_req_addr] = (ref_mem[wr_req_addr] & ~wr_req_bmask) | (wr_req_data & wr_req_bmask);
        if (rg) begin
            e.d = ref_mem[rd_req_addr];
            e.avail = cyc_n + 2;
            rq.push_back(e);
        end
        if (rg || !(rd_req_vld && rd_ok)) streak = 0;
        else if (wg && streak < STARVE) streak++;
        last_rd = rg;
        last_wr = wg;
        @(posedge clk);
        cyc_n++;
        #1;
    endtask

    task automatic idle();
        wr_req_vld = 1'b0;
        rd_req_vld = 1'b0;
    endtask

    task automatic do_write(input logic [8:0] a, input logic [95:0] d, input logic [95:0] m);
        rd_req_vld   = 1'b0;
        wr_req_vld   = 1'b1;
        wr_req_addr  = a;
        wr_req_data  = d;
        wr_req_bmask = m;
        step();
        wr_req_vld = 1'b0;
    endtask

    logic [8:0] a3 [3];
    int         k;
    int         n_rd;

    initial begin
        n_chk = 0; n_fail = 0; cyc_n = 0;
        model_reset();
        cpurst_b = 1'b0; rd_data_rdy = 1'b1;
        idle();
        wr_req_addr = '0; wr_req_data = '0; wr_req_bmask = '0; rd_req_addr = '0;
        #2;
        chk("reset_rd_data_vld", rd_data_vld, 1'b0);
        chk("reset_rd_data", rd_data, 96'h0);
        repeat (2) @(posedge clk);
        #1 cpurst_b = 1'b1;

        for (int i = 0; i < 8; i++) do_write(9'(i), {$urandom, $urandom, $urandom}, '1);

        // Full write then read of the same location, exact two-cycle return.
        do_write(9'h1A5, {12{8'hA5}}, '1);
        rd_req_vld = 1'b1; rd_req_addr = 9'h1A5;
        step();
        chk("t1_accept", last_rd, 1'b1);
        rd_req_vld = 1'b0;
        step();
        chk("t1_vld_t1", last_vld, 1'b0);
        step();
        chk("t1_vld_t2", last_vld, 1'b1);
        chk("t1_data", last_data, {12{8'hA5}});

        // Partial bit-mask write, then a zero-mask write that must change nothing.
        do_write(9'h003, '1, '1);
        do_write(9'h003, '0, {48'h0, {48{1'b1}}});
        do_write(9'h003, '0, '0);
        rd_req_vld = 1'b1; rd_req_addr = 9'h003;
        step();
        rd_req_vld = 1'b0;
        step();
        step();
        chk("t2_data", last_data, 96'hFFFF_FFFF_FFFF_0000_0000_0000);

        // Backpressure: only two reads fit while the consumer stalls.
        a3[0] = 9'h010; a3[1] = 9'h011; a3[2] = 9'h012;
        for (int i = 0; i < 3; i++) do_write(a3[i], {$urandom, $urandom, $urandom}, '1);
        rd_data_rdy = 1'b0;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            rd_req_vld = 1'b1; rd_req_addr = a3[k];
            step();
            if (last_rd) k++;
        end
        chk("t3_accepted_stalled", k, 2);
        rd_data_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (k < 3) begin rd_req_vld = 1'b1; rd_req_addr = a3[k]; end
            else rd_req_vld = 1'b0;
            step();
            if (last_rd) k++;
        end
        chk("t3_third_accepted", k, 3);

        // Starvation bound: four writes, then one read, repeating.
        idle();
        step();
        n_rd = 0;
        for (int i = 0; i < 20; i++) begin
            wr_req_vld = 1'b1; wr_req_addr = 9'h040; wr_req_data = {3{$urandom}}; wr_req_bmask = '1;
            rd_req_vld = 1'b1; rd_req_addr = 9'h003;
            step();
            chk("t4_pattern", last_rd, (i % 5) == 4);
            if (last_rd) n_rd++;
        end
        chk("t4_read_grants", n_rd, 4);
        idle();
        repeat (3) step();

        // Reset while a read is in the SRAM pipe.
        rd_req_vld = 1'b1; rd_req_addr = 9'h1A5;
        step();
        chk("t5a_accept", last_rd, 1'b1);
        idle();
        cpurst_b = 1'b0;
        #1;
        chk("t5a_vld_in_reset", rd_data_vld, 1'b0);
        model_reset();
        step();
        cpurst_b = 1'b1;
        repeat (4) step();

        // Reset while the FIFO holds data.
        rd_data_rdy = 1'b0;
        rd_req_vld = 1'b1; rd_req_addr = 9'h1A5;
        step();
        idle();
        step();
        step();
        chk("t5b_vld_before_reset", last_vld, 1'b1);
        cpurst_b = 1'b0;
        #1;
        chk("t5b_vld_in_reset", rd_data_vld, 1'b0);
        chk("t5b_data_in_reset", rd_data, 96'h0);
        model_reset();
        step();
        cpurst_b = 1'b1;
        rd_data_rdy = 1'b1;
        repeat (4) step();

        // Random traffic on a small address window to force read-after-write hits.
        for (int i = 0; i < 400; i++) begin
            wr_req_vld   = ($urandom_range(0, 9) < 7);
            wr_req_addr  = 9'($urandom_range(0, 7));
            wr_req_data  = {$urandom, $urandom, $urandom};
            wr_req_bmask = ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom, $urandom};
            rd_req_vld   = ($urandom_range(0, 9) < 6);
            rd_req_addr  = 9'($urandom_range(0, 7));
            rd_data_rdy  = ($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        rd_data_rdy = 1'b1;
        repeat (5) step();

`ifdef CT_L2C_SRAM_ACC_PERF_EN
        cpurst_b = 1'b0;
        #1;
        chk("perf_stall_reset", perf_rd_stall_cnt, 32'd0);
        chk("perf_wr_reset", perf_wr_cnt, 32'd0);
        model_reset();
        step();
        cpurst_b = 1'b1;
        for (int i = 0; i < 7; i++) do_write(9'(9'h020 + 9'(i)), {3{$urandom}}, '1);
        rd_data_rdy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rd_req_vld = 1'b1; rd_req_addr = 9'h003;
            step();
        end
        idle();
        chk("perf_rd_stall_cnt", perf_rd_stall_cnt, 32'd10);
        chk("perf_wr_cnt", perf_wr_cnt, 32'd7);
        rd_data_rdy = 1'b1;
        repeat (4) step();
        force dut.r_perf_wr_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_perf_wr_cnt;
        do_write(9'h030, {3{$urandom}}, '1);
        chk("perf_wr_saturate", perf_wr_cnt, 32'hFFFF_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
